// File: rtl/k2mm_io_wrapper_pkg.sv
// Shared constants, FSM state type and LFSR step for the k2mm I/O wrapper.
package k2mm_wrapper_pkg;

    localparam int          LANES     = 4;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] SEED_BASE = 32'hACE1_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Galois right-shift LFSR, one step
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/k2mm_io_wrapper_if.sv
// Compressed pin bundle of the k2mm wrapper: valid strobe, per-lane parity, signature.
interface k2mm_io_wrapper_if;
    import k2mm_wrapper_pkg::*;

    logic             probe_out;
    logic [LANES-1:0] data_out;
    logic             data_valid;

    modport master (output probe_out, output data_out, output data_valid);
    modport slave  (input  probe_out, input  data_out, input  data_valid);

endinterface

// File: rtl/k2mm_io_wrapper_lane.sv
// One compute lane: LFSR operand source, 16x16 multiply, N-term accumulate, E_out register.
module k2mm_lane
    import k2mm_wrapper_pkg::*;
#(
    parameter int DW = 32,
    parameter int K  = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    input  logic          last_i,
    output logic          wr_o,
    output logic [DW-1:0] din_o
);

    localparam logic [31:0] SEED = SEED_BASE | 32'(K + 1);

    logic [31:0]   s_q, s_d;
    logic [31:0]   prod;
    logic [DW-1:0] acc_q, acc_d;
    logic          wr_q;
    logic [DW-1:0] din_q;

    assign s_d   = lfsr_next(s_q);
    assign prod  = {16'd0, s_q[31:16]} * {16'd0, s_q[15:0]};
    assign acc_d = acc_q + DW'(prod);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q   <= SEED;
            acc_q <= '0;
            wr_q  <= 1'b0;
            din_q <= '0;
        end else if (run_i) begin
            s_q <= s_d;
            if (last_i) begin
                // last term closes the dot product straight into the output word
                din_q <= acc_d;
                wr_q  <= 1'b1;
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
                wr_q  <= 1'b0;
            end
        end else begin
            wr_q <= 1'b0;
        end
    end

    assign wr_o  = wr_q;
    assign din_o = din_q;

endmodule

// File: rtl/k2mm_io_wrapper.sv
// 2mm-style kernel wrapper: four LFSR-fed MAC lanes squeezed onto a handful of pins.
// Optional K2MM_WRAPPER_STOP_EN: halt in DONE after FRAMES frames; otherwise free-runs.
module k2mm_io_wrapper
    import k2mm_wrapper_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 32,
    parameter int FRAMES = 1
) (
    input  logic                clk_p,
    input  logic                clk_n,
    input  logic                ap_rst,
    k2mm_io_wrapper_if.master   pins_o
);

    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = (N > 1) ? $clog2(N * N) : 1;

    logic ap_clk;
    // differential receiver: the pair is complementary, so this follows clk_p
    assign ap_clk = clk_p & ~clk_n;

    state_t        state_q;
    logic [TW-1:0] t_q;
    logic [EW-1:0] e_q;
    logic          run, last_t, last_e;

    assign run    = (state_q == RUN);
    assign last_t = (t_q == TW'(N - 1));
    assign last_e = (e_q == EW'(N * N - 1));

`ifdef K2MM_WRAPPER_STOP_EN
    logic [31:0] frm_q;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            e_q     <= '0;
`ifdef K2MM_WRAPPER_STOP_EN
            frm_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    t_q <= last_t ? '0 : t_q + 1'b1;
                    if (last_t)
                        e_q <= last_e ? '0 : e_q + 1'b1;
`ifdef K2MM_WRAPPER_STOP_EN
                    if (last_t && last_e) begin
                        frm_q <= frm_q + 32'd1;
                        if (frm_q == 32'(FRAMES - 1))
                            state_q <= DONE;
                    end
`endif
                end
                default: state_q <= state_q;
            endcase
        end
    end

    logic [LANES-1:0]         wr_vec;
    logic [LANES-1:0][DW-1:0] din_arr;
    logic [LANES-1:0]         par_vec;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        k2mm_lane #(.DW(DW), .K(k)) u_lane (
            .clk_i  (ap_clk),
            .rst_i  (ap_rst),
            .run_i  (run),
            .last_i (last_t),
            .wr_o   (wr_vec[k]),
            .din_o  (din_arr[k])
        );
        assign par_vec[k] = ^din_arr[k];
    end

    logic          E_out_0_write, E_out_1_write, E_out_2_write, E_out_3_write;
    logic [DW-1:0] E_out_0_din,   E_out_1_din,   E_out_2_din,   E_out_3_din;

    assign E_out_0_write = wr_vec[0];
    assign E_out_1_write = wr_vec[1];
    assign E_out_2_write = wr_vec[2];
    assign E_out_3_write = wr_vec[3];
    assign E_out_0_din   = din_arr[0];
    assign E_out_1_din   = din_arr[1];
    assign E_out_2_din   = din_arr[2];
    assign E_out_3_din   = din_arr[3];

    logic             dv_q;
    logic [LANES-1:0] dout_q;
    logic             probe_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            dv_q    <= 1'b0;
            dout_q  <= '0;
            probe_q <= 1'b0;
        end else begin
            dv_q <= |wr_vec;
            for (int k = 0; k < LANES; k++)
                if (wr_vec[k]) dout_q[k] <= par_vec[k];
            if (|wr_vec)
                probe_q <= probe_q ^ (^(par_vec & wr_vec));
        end
    end

    assign pins_o.data_valid = dv_q;
    assign pins_o.data_out   = dout_q;
    assign pins_o.probe_out  = probe_q;

endmodule

// File: tb/tb_k2mm_io_wrapper.sv
// Scoreboard bench for k2mm_io_wrapper: golden LFSR/MAC words queued at reset release.
`timescale 1ns/1ps
module tb_k2mm_io_wrapper;
    import k2mm_wrapper_pkg::*;

    localparam int N = 4;
`ifdef K2MM_WRAPPER_STOP_EN
    localparam int NFR = 1;
`else
    localparam int NFR = 2;
`endif

    typedef logic [3:0][31:0] wvec_t;

    logic clk_p, clk_n, ap_rst;
    k2mm_io_wrapper_if pins();

    k2mm_io_wrapper #(.N(N), .DW(32), .FRAMES(1)) dut (
        .clk_p  (clk_p),
        .clk_n  (clk_n),
        .ap_rst (ap_rst),
        .pins_o (pins)
    );

    initial begin
        clk_p = 1'b0;
        forever #1.667 clk_p = ~clk_p;
    end
    assign clk_n = ~clk_p;

    int          total = 0;
    int          bad   = 0;
    wvec_t       sbq[$];
    logic [3:0]  exp_dout;
    logic        exp_probe;

    function automatic logic [3:0] dut_wr();
        return {dut.E_out_3_write, dut.E_out_2_write, dut.E_out_1_write, dut.E_out_0_write};
    endfunction

    function automatic wvec_t dut_din();
        return {dut.E_out_3_din, dut.E_out_2_din, dut.E_out_1_din, dut.E_out_0_din};
    endfunction

    // golden words from seeds ACE1_0001..0004, pushed as the stimulus is released
    task automatic load_model(input int nw);
        logic [31:0] s[4];
        logic [31:0] acc, p;
        wvec_t       w;
        for (int k = 0; k < 4; k++) s[k] = 32'hACE1_0000 | 32'(k + 1);
        sbq.delete();
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++) begin
                acc = 32'd0;
                for (int t = 0; t < N; t++) begin
                    p   = {16'd0, s[k][31:16]} * {16'd0, s[k][15:0]};
                    acc = acc + p;
                    s[k] = s[k][0] ? ((s[k] >> 1) ^ 32'h8020_0003) : (s[k] >> 1);
                end
                w[k] = acc;
            end
            sbq.push_back(w);
        end
    endtask

    task automatic run_stream(input int nwords, input bit chk_first, input bit chk_frame);
        int         cyc = 0, nw = 0, first_c = -1, last_c = -1;
        logic       prev_wr = 1'b0;
        logic [3:0] wr;
        wvec_t      din, exp_w;
        while (cyc < nwords * N + 40) begin
            @(negedge dut.ap_clk);
            cyc++;
            total++;
            if (pins.data_valid !== prev_wr) begin
                bad++; $display("FAIL data_valid cyc=%0d got=%b want=%b", cyc, pins.data_valid, prev_wr);
            end
            total++;
            if (pins.data_out !== exp_dout) begin
                bad++; $display("FAIL data_out cyc=%0d got=%b want=%b", cyc, pins.data_out, exp_dout);
            end
            total++;
            if (pins.probe_out !== exp_probe) begin
                bad++; $display("FAIL probe_out cyc=%0d got=%b want=%b", cyc, pins.probe_out, exp_probe);
            end
            wr = dut_wr();
            if (wr != 4'h0 && nw < nwords) begin
                din   = dut_din();
                exp_w = sbq.pop_front();
                total++;
                if (wr !== 4'hF) begin
                    bad++; $display("FAIL lanes_together cyc=%0d got=%b want=1111", cyc, wr);
                end
                $display("word %0d: %h %h %h %h", nw, din[0], din[1], din[2], din[3]);
                for (int k = 0; k < 4; k++) begin
                    total++;
                    if (din[k] !== exp_w[k]) begin
                        bad++; $display("FAIL din lane%0d word%0d got=%h want=%h", k, nw, din[k], exp_w[k]);
                    end
                    exp_dout[k] = ^exp_w[k];
                    exp_probe   = exp_probe ^ (^exp_w[k]);
                end
                if (nw == 0) begin
                    first_c = cyc;
                    if (chk_first) begin
                        total++;
                        if (cyc !== N + 1) begin
                            bad++; $display("FAIL first_write_latency got=%0d want=%0d", cyc, N + 1);
                        end
                    end
                end else begin
                    total++;
                    if (cyc - last_c !== N) begin
                        bad++; $display("FAIL write_gap word%0d got=%0d want=%0d", nw, cyc - last_c, N);
                    end
                end
                if (chk_frame && nw == N * N) begin
                    total++;
                    if (cyc - first_c !== N * N * N) begin
                        bad++; $display("FAIL frame2_offset got=%0d want=%0d", cyc - first_c, N * N * N);
                    end
                end
                last_c = cyc;
                nw++;
            end
            prev_wr = (wr != 4'h0);
            if (nw == nwords && !prev_wr) break;
        end
        total++;
        if (nw !== nwords) begin
            bad++; $display("FAIL stream_timeout got=%0d want=%0d words", nw, nwords);
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({pins.data_valid, pins.data_out, pins.probe_out, dut_wr()} !== 10'd0) begin
            bad++; $display("FAIL %s_pins got dv=%b do=%b pr=%b wr=%b want=0", tag,
                            pins.data_valid, pins.data_out, pins.probe_out, dut_wr());
        end
        total++;
        if (dut_din() !== '0) begin
            bad++; $display("FAIL %s_din got=%h want=0", tag, dut_din());
        end
    endtask

    task automatic release_reset();
        @(negedge dut.ap_clk);
        exp_dout  = 4'h0;
        exp_probe = 1'b0;
        ap_rst    = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (5) begin
            @(negedge dut.ap_clk);
            check_all_zero("reset_hold");
        end
    endtask

    task automatic test_frames();
        load_model(NFR * N * N);
        release_reset();
        run_stream(NFR * N * N, 1'b1, NFR > 1);
    endtask

    task automatic test_stop();
`ifdef K2MM_WRAPPER_STOP_EN
        repeat (80) begin
            @(negedge dut.ap_clk);
            total++;
            if (dut_wr() !== 4'h0 || pins.data_valid !== 1'b0) begin
                bad++; $display("FAIL done_quiet got wr=%b dv=%b want 0", dut_wr(), pins.data_valid);
            end
            total++;
            if (pins.probe_out !== exp_probe || pins.data_out !== exp_dout) begin
                bad++; $display("FAIL done_hold got pr=%b do=%b want pr=%b do=%b",
                                pins.probe_out, pins.data_out, exp_probe, exp_dout);
            end
        end
`else
        // free-running: keep the frame stream going a few more words
        load_model(NFR * N * N + 4);
        repeat (NFR * N * N) void'(sbq.pop_front());
        repeat (N - 2) @(negedge dut.ap_clk);
        run_stream(4, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_midrun_reset();
        ap_rst = 1'b1;
        @(negedge dut.ap_clk);
        load_model(2);
        release_reset();
        run_stream(2, 1'b1, 1'b0);
        @(posedge dut.ap_clk);
        #0.8 ap_rst = 1'b1;
        #0.3 check_all_zero("async_reset");
        repeat (3) @(negedge dut.ap_clk);
        check_all_zero("reset_again");
        load_model(N * N);
        release_reset();
        run_stream(N * N, 1'b1, 1'b0);
    endtask

    initial begin
        exp_dout  = 4'h0;
        exp_probe = 1'b0;
        test_reset();
        test_frames();
        test_stop();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
